// File: rtl/tnn_pkg.sv
// tnn_pkg: shared state encoding, chunk width and accumulator sizing rule for the ternary neuron.
package tnn_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, CNT_P, CNT_N, OUT} state_t;
  localparam int CHUNK_W = 16;
  function automatic int min_acc_w(input int n_chunks);
    return $clog2(CHUNK_W * n_chunks + 1) + 1;
  endfunction
endpackage

// File: rtl/tnn_popcount16.sv
// tnn_popcount16: combinational 16-input population count, swappable for an approximate variant.
module tnn_popcount16
  import tnn_pkg::*;
(
  input  logic [CHUNK_W-1:0] d,
  output logic [4:0]         cnt
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < CHUNK_W; i++) cnt = cnt + 5'(d[i]);
  end
endmodule

// File: rtl/tnn_ternary_neuron_seq.sv
// tnn_ternary_neuron_seq: chunk-serial ternary neuron, one shared popcount for +1 and -1 weight masks.
module tnn_ternary_neuron_seq
  import tnn_pkg::*;
#(
  parameter int N_CHUNKS = 4,
  parameter int ACC_W    = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [ACC_W-1:0] threshold,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CHUNK_W-1:0]      in_data,
  input  logic [CHUNK_W-1:0]      w_pos,
  input  logic [CHUNK_W-1:0]      w_neg,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_bit,
  output logic signed [ACC_W-1:0] out_sum
);
  localparam int CNT_W = N_CHUNKS > 1 ? $clog2(N_CHUNKS) : 1;
  if (N_CHUNKS < 1 || N_CHUNKS > 16 || ACC_W < min_acc_w(N_CHUNKS)) begin : g_param_chk
    $error("tnn_ternary_neuron_seq: illegal N_CHUNKS/ACC_W combination");
  end
  state_t                  state, state_nxt;
  logic [CHUNK_W-1:0]      d_q, wp_q, wn_q, pc_in;
  logic [4:0]              pc;
  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] acc, thr, acc_nxt;
  logic                    last;
  assign last = cnt == CNT_W'(N_CHUNKS - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (in_valid) state_nxt = CNT_P;
      CNT_P:   state_nxt = CNT_N;
      CNT_N:   state_nxt = last ? OUT : LOAD;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    in_ready  = state == LOAD;
    busy      = state != IDLE;
    out_valid = state == OUT;
  end
  // Conflicting weight bits (set in both masks) are excluded from both counts.
  assign pc_in   = state == CNT_P ? d_q & wp_q & ~wn_q : d_q & wn_q & ~wp_q;
  assign acc_nxt = state == CNT_P ? acc + $signed(ACC_W'(pc)) : acc - $signed(ACC_W'(pc));
  tnn_popcount16 u_popcount (.d(pc_in), .cnt(pc));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      d_q     <= '0;
      wp_q    <= '0;
      wn_q    <= '0;
      acc     <= '0;
      thr     <= '0;
      cnt     <= '0;
      out_sum <= '0;
      out_bit <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          thr <= threshold;
          acc <= '0;
          cnt <= '0;
        end
        LOAD: if (in_valid) begin
          d_q  <= in_data;
          wp_q <= w_pos;
          wn_q <= w_neg;
        end
        CNT_P: acc <= acc_nxt;
        CNT_N: begin
          acc <= acc_nxt;
          if (last) begin
            out_sum <= acc_nxt;
            out_bit <= acc_nxt >= thr;
          end else cnt <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_tnn_ternary_neuron_seq.sv
// tb_tnn_ternary_neuron_seq: directed vectors with hand-computed sums for the ternary neuron.
module tb_tnn_ternary_neuron_seq;
  logic              clk = 0, rst_n = 0, start = 0, in_valid = 0, out_ready = 0;
  logic signed [8:0] threshold = '0;
  logic [15:0]       in_data = '0, w_pos = '0, w_neg = '0;
  logic              in_ready, busy, out_valid, out_bit;
  logic signed [8:0] out_sum;
  logic [15:0]       cd [4], cp [4], cn [4];
  int                n_chk = 0, n_pass = 0;
  tnn_ternary_neuron_seq #(.N_CHUNKS(4), .ACC_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .threshold(threshold),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .w_pos(w_pos), .w_neg(w_neg), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_bit(out_bit), .out_sum(out_sum)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic fill(input logic [15:0] d, input logic [15:0] p, input logic [15:0] n);
    for (int k = 0; k < 4; k++) begin
      cd[k] = d;
      cp[k] = p;
      cn[k] = n;
    end
  endtask
  task automatic run(input string tag, input int thr, input int gap_chunk, input int gap_len,
                     input int hold, input int exp_sum, input int exp_bit);
    int cyc, to;
    start = 1;
    threshold = 9'(thr);
    tick();
    start = 0;
    threshold = 9'sd255;
    cyc = 1;
    for (int k = 0; k < 4; k++) begin
      to = 0;
      while (!in_ready && to < 20) begin
        tick();
        cyc++;
        to++;
      end
      if (!in_ready) chk({tag, "_load_timeout"}, 0, 1);
      start = 0;
      in_valid = 0;
      if (k == gap_chunk)
        for (int g = 0; g < gap_len; g++) begin
          chk({tag, "_gap_ready"}, int'(in_ready), 1);
          tick();
          cyc++;
        end
      in_valid = 1;
      in_data = cd[k];
      w_pos = cp[k];
      w_neg = cn[k];
      tick();
      cyc++;
      // Junk stimulus while not in LOAD must be ignored.
      in_valid = k < 3 && k + 1 != gap_chunk;
      start = in_valid;
      in_data = '1;
      w_pos = '1;
      w_neg = '0;
    end
    to = 0;
    while (!out_valid && to < 40) begin
      tick();
      cyc++;
      to++;
    end
    in_valid = 0;
    start = 0;
    chk({tag, "_valid"}, int'(out_valid), 1);
    if (gap_len == 0) chk({tag, "_latency"}, cyc, 13);
    for (int h = 0; h < hold; h++) begin
      chk({tag, "_hold_valid"}, int'(out_valid), 1);
      chk({tag, "_hold_sum"}, int'(out_sum), exp_sum);
      tick();
    end
    chk({tag, "_sum"}, int'(out_sum), exp_sum);
    chk({tag, "_bit"}, int'(out_bit), exp_bit);
    out_ready = 1;
    start = 1;
    tick();
    out_ready = 0;
    start = 0;
    chk({tag, "_idle_busy"}, int'(busy), 0);
    chk({tag, "_idle_valid"}, int'(out_valid), 0);
  endtask
  initial begin
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(in_ready), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_bit", int'(out_bit), 0);
    chk("rst_sum", int'(out_sum), 0);
    tick();
    rst_n = 1;
    tick();
    fill(16'hFFFF, 16'hFFFF, 16'h0000);
    run("pos", 64, -1, 0, 0, 64, 1);
    fill(16'h0000, 16'h0000, 16'h0000);
    cd[0] = 16'h0F0F;
    cp[0] = 16'h00FF;
    cn[0] = 16'hFF00;
    run("mix_t0", 0, -1, 0, 0, 0, 1);
    run("mix_t1", 1, -1, 0, 0, 0, 0);
    fill(16'hFFFF, 16'hFFFF, 16'hFFFF);
    run("conflict", -1, -1, 0, 0, 0, 1);
    cd = '{16'hFFFF, 16'hFFFF, 16'h1234, 16'hFFFF};
    cp = '{16'h00FF, 16'h0000, 16'hFFFF, 16'hF000};
    cn = '{16'h0000, 16'h0FFF, 16'h0000, 16'hF00F};
    run("varied", -3, -1, 0, 0, -3, 1);
    fill(16'hFFFF, 16'hFFFF, 16'h0000);
    run("bp_in", 64, 2, 5, 0, 64, 1);
    run("bp_out", 64, -1, 0, 7, 64, 1);
    fill(16'hFFFF, 16'h0000, 16'hFFFF);
    run("neg", -64, -1, 0, 0, -64, 1);
    start = 1;
    threshold = 0;
    tick();
    start = 0;
    for (int k = 0; k < 3; k++) begin
      for (int to = 0; to < 20 && !in_ready; to++) tick();
      in_valid = 1;
      in_data = 16'hFFFF;
      w_pos = 16'hFFFF;
      w_neg = 16'h0000;
      tick();
      in_valid = 0;
    end
    tick();
    rst_n = 0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_ready", int'(in_ready), 0);
    chk("abort_valid", int'(out_valid), 0);
    chk("abort_sum", int'(out_sum), 0);
    tick();
    rst_n = 1;
    tick();
    chk("abort_stay_idle", int'(busy), 0);
    run("post_rst", -63, -1, 0, 0, -64, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
